// File: rtl/dexterity_game_ctrl.sv
// Round sequencer for the reflex game: target selection, hit/miss scoring,
// per-second countdown and end-of-game handling.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | after reset, waiting for start; no target lit
// S_PLAY   | target lit, waiting for a press to score
// S_WAIT_REL | press scored, waiting for all buttons released
// S_DONE   | countdown expired; results held, target dark
module dexterity_game_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned GAME_TIME     = 60,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] btn,
  output logic [7:0] target_led,
  output logic [6:0] score,
  output logic [6:0] misses,
  output logic [6:0] time_left,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]    TIME_INIT = 7'(GAME_TIME);
  localparam logic [6:0]    CNT_MAX   = 7'd99;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PLAY     = 2'd1,
    S_WAIT_REL = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]    r_btn_meta;
  logic [7:0]    r_btn_sync;
  logic [7:0]    r_lfsr;
  logic [7:0]    r_target;
  logic [6:0]    r_score;
  logic [6:0]    r_misses;
  logic [6:0]    r_time_left;
  logic [TW-1:0] r_tick;
  logic          r_hit_pulse;
  logic          r_miss_pulse;

  logic          w_lfsr_fb;
  logic [2:0]    w_cur_idx;
  logic          w_cur_valid;
  logic [2:0]    w_new_idx;
  logic [7:0]    w_new_target;
  logic          w_running;
  logic          w_wrap;
  logic          w_expire;
  logic          w_load;
  logic          w_hit;
  logic          w_miss;

  // Two-stage synchronizer for the asynchronous player inputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_btn_meta <= 8'd0;
      r_btn_sync <= 8'd0;
    end else begin
      r_btn_meta <= btn;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Free-running LFSR (x^8+x^6+x^5+x^4+1); never paused so target choice depends on player timing
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_lfsr <= LFSR_SEED;
    else         r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
  end

  // Encode the current target so the next one can be forced to differ
  always_comb begin
    w_cur_idx   = 3'd0;
    w_cur_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (r_target[i]) begin
        w_cur_idx   = 3'(i);
        w_cur_valid = 1'b1;
      end
    end
  end

  assign w_new_idx    = (w_cur_valid && (r_lfsr[2:0] == w_cur_idx)) ? (r_lfsr[2:0] + 3'd1)
                                                                    : r_lfsr[2:0];
  assign w_new_target = 8'd1 << w_new_idx;

  assign w_running = (r_state == S_PLAY) || (r_state == S_WAIT_REL);
  assign w_wrap    = w_running && (r_tick == TICK_MAX);
  assign w_expire  = w_wrap && (r_time_left == 7'd1);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and scoring strobes; expiry takes priority over any press on the same edge
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_PLAY;
          w_load      = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_expire) begin
          w_state_nxt = S_DONE;
        end else if (r_btn_sync == r_target) begin
          w_state_nxt = S_WAIT_REL;
          w_hit       = 1'b1;
        end else if ((r_btn_sync & ~r_target) != 8'd0) begin
          w_state_nxt = S_WAIT_REL;
          w_miss      = 1'b1;
        end
      end
      S_WAIT_REL: begin
        if (w_expire)                  w_state_nxt = S_DONE;
        else if (r_btn_sync == 8'd0)   w_state_nxt = S_PLAY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Game datapath: target, saturating counters, countdown and registered pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_target     <= 8'd0;
      r_score      <= 7'd0;
      r_misses     <= 7'd0;
      r_time_left  <= TIME_INIT;
      r_tick       <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_hit_pulse  <= w_hit;
      r_miss_pulse <= w_miss;
      if (w_load) begin
        r_score     <= 7'd0;
        r_misses    <= 7'd0;
        r_time_left <= TIME_INIT;
        r_tick      <= '0;
        r_target    <= w_new_target;
      end else begin
        if (w_running) begin
          r_tick <= w_wrap ? '0 : (r_tick + TW'(1));
          if (w_wrap && (r_time_left != 7'd0)) r_time_left <= r_time_left - 7'd1;
        end
        if (w_expire) r_target <= 8'd0;
        if (w_hit) begin
          r_target <= w_new_target;
          if (r_score != CNT_MAX) r_score <= r_score + 7'd1;
        end
        if (w_miss && (r_misses != CNT_MAX)) r_misses <= r_misses + 7'd1;
      end
    end
  end

  assign target_led = r_target;
  assign score      = r_score;
  assign misses     = r_misses;
  assign time_left  = r_time_left;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign game_over  = (r_state == S_DONE);

endmodule

// File: tb/tb_dexterity_game_ctrl.sv
// Directed bench for dexterity_game_ctrl: reset, hit, miss, countdown,
// expiry/hit collision, saturation and asynchronous reset.
module tb_dexterity_game_ctrl;

  localparam int TPS = 10;
  localparam int GT  = 5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] btn = 8'd0;
  logic [7:0] target_led;
  logic [6:0] score, misses, time_left;
  logic       hit_pulse, miss_pulse, game_over;

  logic       start2 = 1'b0;
  logic [7:0] btn2 = 8'd0;
  logic [7:0] target_led2;
  logic [6:0] score2, misses2, time_left2;
  logic       hit_pulse2, miss_pulse2, game_over2;

  int errors = 0;
  int checks = 0;
  int n_hit = 0;
  int n_miss = 0;
  int n_hit2 = 0;
  logic [7:0] m_lfsr;
  logic [7:0] exp_tgt;

  dexterity_game_ctrl #(.TICKS_PER_SEC(TPS), .GAME_TIME(GT), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .resetn(resetn), .start(start), .btn(btn),
    .target_led(target_led), .score(score), .misses(misses), .time_left(time_left),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
  );

  // Long game so 100 hits fit before expiry
  dexterity_game_ctrl #(.TICKS_PER_SEC(1000), .GAME_TIME(99), .LFSR_SEED(8'hA5)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .btn(btn2),
    .target_led(target_led2), .score(score2), .misses(misses2), .time_left(time_left2),
    .hit_pulse(hit_pulse2), .miss_pulse(miss_pulse2), .game_over(game_over2)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left, seeded at reset
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 8'hA5;
    else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  always @(negedge clk) begin
    if (hit_pulse)  n_hit++;
    if (miss_pulse) n_miss++;
    if (hit_pulse2) n_hit2++;
  end

  function automatic int idx_of(input logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [7:0] next_tgt(input logic [7:0] l, input logic [7:0] cur);
    logic [2:0] idx;
    idx = l[2:0];
    if (cur != 8'd0 && int'(idx) == idx_of(cur)) idx = idx + 3'd1;
    return 8'd1 << idx;
  endfunction

  task automatic do_start(output logic [7:0] exp);
    @(negedge clk);
    start = 1'b1;
    exp = next_tgt(m_lfsr, 8'h00);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (target_led !== 8'd0) begin errors++; $display("FAIL reset_target got %0h want 0", target_led); end
    checks++; if (score !== 7'd0 || misses !== 7'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", score, misses); end
    checks++; if (time_left !== 7'(GT)) begin errors++; $display("FAIL reset_time got %0d want %0d", time_left, GT); end
    checks++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b want 000", hit_pulse, miss_pulse, game_over); end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (target_led !== 8'd0 || game_over !== 1'b0) begin errors++; $display("FAIL idle_hold got tgt=%0h go=%b want 0/0", target_led, game_over); end
  endtask

  task automatic test_start();
    do_start(exp_tgt);
    checks++; if (target_led !== exp_tgt) begin errors++; $display("FAIL start_target got %0h want %0h", target_led, exp_tgt); end
    checks++; if (!$onehot(target_led)) begin errors++; $display("FAIL start_onehot got %0h want one-hot", target_led); end
    checks++; if (time_left !== 7'(GT) || score !== 7'd0) begin errors++; $display("FAIL start_vals got t=%0d s=%0d want %0d/0", time_left, score, GT); end
  endtask

  task automatic test_hit();
    logic [7:0] ne;
    int h0;
    h0 = n_hit;
    @(negedge clk); btn = exp_tgt;
    @(negedge clk);
    @(negedge clk);
    ne = next_tgt(m_lfsr, exp_tgt);
    checks++; if (hit_pulse !== 1'b0 || score !== 7'd0) begin errors++; $display("FAIL hit_early got p=%b s=%0d want 0/0", hit_pulse, score); end
    @(negedge clk);
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL hit_pulse got %b want 1", hit_pulse); end
    checks++; if (score !== 7'd1) begin errors++; $display("FAIL hit_score got %0d want 1", score); end
    checks++; if (target_led !== ne) begin errors++; $display("FAIL hit_newtgt got %0h want %0h", target_led, ne); end
    checks++; if (target_led === exp_tgt) begin errors++; $display("FAIL hit_tgt_differs got %0h want not %0h", target_led, exp_tgt); end
    @(negedge clk);
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_pulse_width got %b want 0", hit_pulse); end
    repeat (2) @(negedge clk);
    btn = 8'd0;
    repeat (4) @(negedge clk);
    checks++; if (n_hit - h0 != 1 || score !== 7'd1) begin errors++; $display("FAIL hit_hold got pulses=%0d s=%0d want 1/1", n_hit - h0, score); end
    exp_tgt = ne;
  endtask

  task automatic test_miss();
    int m0;
    m0 = n_miss;
    @(negedge clk); btn = exp_tgt | {exp_tgt[6:0], exp_tgt[7]};
    repeat (3) @(negedge clk);
    checks++; if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0) begin errors++; $display("FAIL miss_pulse got m=%b h=%b want 1/0", miss_pulse, hit_pulse); end
    checks++; if (misses !== 7'd1 || score !== 7'd1) begin errors++; $display("FAIL miss_counts got m=%0d s=%0d want 1/1", misses, score); end
    checks++; if (target_led !== exp_tgt) begin errors++; $display("FAIL miss_target got %0h want %0h", target_led, exp_tgt); end
    @(negedge clk);
    btn = 8'd0;
    repeat (4) @(negedge clk);
    checks++; if (n_miss - m0 != 1) begin errors++; $display("FAIL miss_count_pulses got %0d want 1", n_miss - m0); end
  endtask

  task automatic test_game_end();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (game_over) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL end_timeout got game_over=0 want 1 within 100 cycles"); end
    checks++; if (target_led !== 8'd0 || time_left !== 7'd0) begin errors++; $display("FAIL end_vals got tgt=%0h t=%0d want 0/0", target_led, time_left); end
    checks++; if (score !== 7'd1 || misses !== 7'd1) begin errors++; $display("FAIL end_hold got s=%0d m=%0d want 1/1", score, misses); end
  endtask

  task automatic test_countdown();
    int h0, m0;
    do_start(exp_tgt);
    checks++; if (score !== 7'd0 || misses !== 7'd0 || time_left !== 7'(GT)) begin errors++; $display("FAIL restart_vals got s=%0d m=%0d t=%0d want 0/0/%0d", score, misses, time_left, GT); end
    checks++; if (target_led !== exp_tgt) begin errors++; $display("FAIL restart_target got %0h want %0h", target_led, exp_tgt); end
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 20) start = 1'b1;
      if (k == 21) start = 1'b0;
      checks++; if (time_left !== 7'(GT - k / TPS)) begin errors++; $display("FAIL countdown k=%0d got %0d want %0d", k, time_left, GT - k / TPS); end
      if (k == 49) begin
        checks++; if (game_over !== 1'b0 || !$onehot(target_led)) begin errors++; $display("FAIL pre_expiry got go=%b tgt=%0h want 0/one-hot", game_over, target_led); end
      end
    end
    checks++; if (game_over !== 1'b1 || target_led !== 8'd0) begin errors++; $display("FAIL expiry got go=%b tgt=%0h want 1/0", game_over, target_led); end
    h0 = n_hit; m0 = n_miss;
    btn = 8'hFF;
    repeat (8) @(negedge clk);
    btn = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (n_hit != h0 || n_miss != m0 || score !== 7'd0 || misses !== 7'd0) begin errors++; $display("FAIL done_ignore got s=%0d m=%0d pulses=%0d want 0/0/0", score, misses, n_hit - h0 + n_miss - m0); end
    checks++; if (game_over !== 1'b1 || time_left !== 7'd0 || target_led !== 8'd0) begin errors++; $display("FAIL done_hold got go=%b t=%0d tgt=%0h want 1/0/0", game_over, time_left, target_led); end
  endtask

  task automatic test_expiry_hit();
    int h0;
    do_start(exp_tgt);
    h0 = n_hit;
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      if (k == 47) btn = exp_tgt;
      if (k == 49) begin
        checks++; if (game_over !== 1'b0 || score !== 7'd0) begin errors++; $display("FAIL collide_pre got go=%b s=%0d want 0/0", game_over, score); end
      end
      if (k == 50) begin
        checks++; if (game_over !== 1'b1 || score !== 7'd0 || hit_pulse !== 1'b0) begin errors++; $display("FAIL collide got go=%b s=%0d p=%b want 1/0/0", game_over, score, hit_pulse); end
      end
    end
    btn = 8'd0;
    checks++; if (n_hit != h0) begin errors++; $display("FAIL collide_pulses got %0d want 0", n_hit - h0); end
  endtask

  task automatic test_saturation();
    logic [7:0] e2, ne;
    @(negedge clk);
    start2 = 1'b1;
    e2 = next_tgt(m_lfsr, 8'h00);
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk); btn2 = e2;
      repeat (2) @(negedge clk);
      ne = next_tgt(m_lfsr, e2);
      @(negedge clk);
      if (i == 100) begin
        checks++; if (hit_pulse2 !== 1'b1 || score2 !== 7'd99) begin errors++; $display("FAIL sat_hit got p=%b s=%0d want 1/99", hit_pulse2, score2); end
      end
      @(negedge clk); btn2 = 8'd0;
      repeat (3) @(negedge clk);
      e2 = ne;
      if (i == 50) begin
        checks++; if (score2 !== 7'd50) begin errors++; $display("FAIL sat_mid got %0d want 50", score2); end
      end
      if (i == 99) begin
        checks++; if (score2 !== 7'd99 || target_led2 !== e2) begin errors++; $display("FAIL sat_99 got s=%0d tgt=%0h want 99/%0h", score2, target_led2, e2); end
      end
    end
    checks++; if (score2 !== 7'd99 || n_hit2 != 100) begin errors++; $display("FAIL sat_final got s=%0d pulses=%0d want 99/100", score2, n_hit2); end
  endtask

  task automatic test_async_reset();
    do_start(exp_tgt);
    repeat (12) @(negedge clk);
    btn = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (miss_pulse !== 1'b1 || misses !== 7'd1 || time_left !== 7'(GT - 1)) begin errors++; $display("FAIL pre_reset got p=%b m=%0d t=%0d want 1/1/%0d", miss_pulse, misses, time_left, GT - 1); end
    #1 resetn = 1'b0;
    #1;
    checks++; if (miss_pulse !== 1'b0 || misses !== 7'd0 || target_led !== 8'd0) begin errors++; $display("FAIL async_reset got p=%b m=%0d tgt=%0h want 0/0/0", miss_pulse, misses, target_led); end
    checks++; if (time_left !== 7'(GT) || game_over !== 1'b0 || score !== 7'd0) begin errors++; $display("FAIL async_reset_time got t=%0d go=%b s=%0d want %0d/0/0", time_left, game_over, score, GT); end
    btn = 8'd0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    do_start(exp_tgt);
    checks++; if (target_led !== exp_tgt || time_left !== 7'(GT) || score !== 7'd0 || misses !== 7'd0) begin errors++; $display("FAIL post_reset_start got tgt=%0h t=%0d s=%0d m=%0d want %0h/%0d/0/0", target_led, time_left, score, misses, exp_tgt, GT); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_miss();
    test_game_end();
    test_countdown();
    test_expiry_hit();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
